// File: rtl/uart_rx_port_pkg.sv
// Shared constants for the UART receive port:
// register offsets, STATUS bit map, defaults.
package uart_rx_port_pkg;

  localparam int UART_BAUD_DIV   = 234;
  localparam int UART_FIFO_DEPTH = 16;

  localparam logic [31:0] UART_DATA_OFS   = 32'h0;
  localparam logic [31:0] UART_STATUS_OFS = 32'h4;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_CNT  = 4;

  function automatic logic [31:0] status_word(
    input logic [8:0] cnt,
    input logic       ferr,
    input logic       ovr,
    input logic       full,
    input logic       ne
  );
    logic [31:0] w;
    w = '0;
    w[ST_CNT +: 9] = cnt;
    w[ST_FERR]     = ferr;
    w[ST_OVR]      = ovr;
    w[ST_FULL]     = full;
    w[ST_NE]       = ne;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_port_sync_fifo.sv
// Generic synchronous FIFO with head peek,
// occupancy count and a dropped-push strobe.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with RX FIFO and a
// two-register (DATA/STATUS) bus window.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_BAUD_DIV,
  parameter int FIFO_DEPTH   = UART_FIFO_DEPTH,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        uart_ren,
  input  logic [31:0] addr,
  output logic [31:0] uart_out,
  output logic        rx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             sync1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;

  logic ld_half, ld_full, dec, clr;
  logic shift, idx_clr, fsm_push, ferr_set;

  logic          ren_q;
  logic          rd_evt;
  logic          sel_status;
  logic          sel_data;
  logic          data_evt;
  logic          stat_evt;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          drop;
  logic          overrun;
  logic          frame_err;
  logic          unused_addr;

  assign unused_addr = ^{addr[31:3], addr[1:0]};
  assign tick = cnt == '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (tick)
                 state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_idx == 3'd7)
                 state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_WAIT;
      S_WAIT:  if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    dec      = 1'b0;
    clr      = 1'b0;
    shift    = 1'b0;
    idx_clr  = 1'b0;
    fsm_push = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        ld_half = !rx_s;
        clr     = rx_s;
      end
      S_START: begin
        dec     = !tick;
        ld_full = tick && !rx_s;
        idx_clr = tick && !rx_s;
        clr     = tick && rx_s;
      end
      S_DATA: begin
        dec     = !tick;
        ld_full = tick;
        shift   = tick;
      end
      S_STOP: begin
        dec      = !tick;
        fsm_push = tick && rx_s;
        ferr_set = tick && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (ld_half)      cnt <= HALF;
      else if (ld_full) cnt <= FULL;
      else if (dec)     cnt <= cnt - CNT_W'(1);
      else if (clr)     cnt <= '0;
      if (idx_clr)    bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 3'd1;
      if (shift) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // Edge-detect the bus strobe so a held read acts once.
  assign rd_evt     = uart_ren && !ren_q;
  assign sel_status = addr[2];
  assign sel_data   = !addr[2];
  assign data_evt   = rd_evt && sel_data;
  assign stat_evt   = rd_evt && sel_status;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fsm_push),
    .din   (shreg),
    .pop   (data_evt),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // Set beats clear on a concurrent STATUS read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ren_q     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      ren_q     <= uart_ren;
      overrun   <= drop | (overrun & !stat_evt);
      frame_err <= ferr_set | (frame_err & !stat_evt);
      rx_irq    <= !empty;
    end
  end

  always_comb begin
    uart_out = '0;
    unique case (1'b1)
      sel_data:
        uart_out = {!empty, 23'b0,
                    empty ? 8'h00 : head};
      sel_status:
        uart_out = status_word(9'(count), frame_err,
                               overrun, full, !empty);
      default: uart_out = '0;
    endcase
  end

endmodule
